// File: rtl/coherence_memory_control.sv
// Memory controller below two CPUs' icaches/dcaches: arbitrates RAM access and runs the
// snoop-based MSI transaction (snoop, cache-to-cache supply or RAM fill) for data misses.
module coherence_memory_control #(
  parameter int unsigned CPUS     = 2,
  parameter int unsigned BLKWORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN        [CPUS],
  input  logic [31:0] iaddr       [CPUS],
  output logic        iwait       [CPUS],
  output logic [31:0] iload       [CPUS],
  input  logic        dREN        [CPUS],
  input  logic        dWEN        [CPUS],
  input  logic [31:0] daddr       [CPUS],
  input  logic [31:0] dstore      [CPUS],
  output logic        dwait       [CPUS],
  output logic [31:0] dload       [CPUS],
  input  logic        cctrans     [CPUS],
  input  logic        ccwrite     [CPUS],
  output logic        ccwait      [CPUS],
  output logic        ccinv       [CPUS],
  output logic [31:0] ccsnoopaddr [CPUS],
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  if (CPUS != 2 || BLKWORDS != 2) begin : g_param_check
    $fatal(1, "coherence_memory_control supports only CPUS=2 and BLKWORDS=2");
  end

  typedef enum logic [3:0] {
    StIdle, StIfetch, StWb, StSnoop, StSupply1, StSupply2, StFill1, StFill2, StErr
  } state_e;

  localparam logic [1:0] RamAccess = 2'd2;
  localparam logic [1:0] RamError  = 2'd3;

  state_e          state_q;
  logic            cpu_q, rr_q, ilast_q, ccw_q, hit_q;
  logic [31:0]     addr_q;
  logic [CPUS-1:0] dreq, ireq;
  logic            dsel, isel, oth, ram_ok, ram_err;
  logic [31:0]     ram_a;

  assign oth     = ~cpu_q;
  assign ram_ok  = (ramstate == RamAccess);
  assign ram_err = (ramstate == RamError);

  always_comb begin
    for (int i = 0; i < CPUS; i++) begin
      dreq[i] = dREN[i] | dWEN[i];
      ireq[i] = iREN[i];
    end
    dsel = dreq[rr_q] ? rr_q : ~rr_q;
    isel = (&ireq) ? ~ilast_q : ireq[1];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      cpu_q   <= 1'b0;
      rr_q    <= 1'b0;
      ilast_q <= 1'b1;
      ccw_q   <= 1'b0;
      hit_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (|dreq) begin
            cpu_q <= dsel;
            if (dWEN[dsel] && !cctrans[dsel]) begin
              state_q <= StWb;
            end else begin
              state_q <= StSnoop;
              addr_q  <= daddr[dsel] & ~32'h4;
              ccw_q   <= ccwrite[dsel];
            end
          end else if (|ireq) begin
            cpu_q   <= isel;
            ilast_q <= isel;
            state_q <= StIfetch;
          end
        end
        StIfetch: begin
          if (ram_err) state_q <= StErr;
          else if (ram_ok) state_q <= StIdle;
        end
        StWb, StSupply2, StFill2: begin
          if (ram_err) begin
            state_q <= StErr;
          end else if (ram_ok) begin
            state_q <= StIdle;
            rr_q    <= oth;
          end
        end
        StSnoop: begin
          hit_q   <= cctrans[oth];
          state_q <= (cctrans[oth] && ccwrite[oth]) ? StSupply1 : StFill1;
        end
        StSupply1: begin
          if (ram_err) state_q <= StErr;
          else if (ram_ok) state_q <= StSupply2;
        end
        StFill1: begin
          if (ram_err) state_q <= StErr;
          else if (ram_ok) state_q <= StFill2;
        end
        StErr:   state_q <= StErr;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < CPUS; i++) begin
      iwait[i]       = 1'b1;
      iload[i]       = '0;
      dwait[i]       = 1'b1;
      dload[i]       = '0;
      ccwait[i]      = 1'b0;
      ccinv[i]       = 1'b0;
      ccsnoopaddr[i] = '0;
    end
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramstore = '0;
    ram_a    = '0;
    case (state_q)
      StIfetch: begin
        ramREN        = 1'b1;
        ram_a         = iaddr[cpu_q];
        iwait[cpu_q]  = ~ram_ok;
        iload[cpu_q]  = ramload;
      end
      StWb: begin
        ramWEN       = 1'b1;
        ram_a        = daddr[cpu_q];
        ramstore     = dstore[cpu_q];
        dwait[cpu_q] = ~ram_ok;
      end
      StSnoop: begin
        ccwait[oth]      = 1'b1;
        ccsnoopaddr[oth] = addr_q;
      end
      // Dirty block in the other cache: forward it and write it back in the same beat.
      StSupply1, StSupply2: begin
        ccwait[oth]      = 1'b1;
        ccsnoopaddr[oth] = addr_q;
        ccinv[oth]       = (state_q == StSupply2) && ccw_q;
        ramWEN           = 1'b1;
        ram_a            = (state_q == StSupply2) ? (addr_q | 32'h4) : addr_q;
        ramstore         = dstore[oth];
        dload[cpu_q]     = dstore[oth];
        dwait[cpu_q]     = ~ram_ok;
      end
      StFill1, StFill2: begin
        ccinv[oth]   = (state_q == StFill1) && ccw_q && hit_q;
        ramREN       = 1'b1;
        ram_a        = (state_q == StFill2) ? (addr_q | 32'h4) : addr_q;
        dload[cpu_q] = ramload;
        dwait[cpu_q] = ~ram_ok;
      end
      default: ;
    endcase
    ramaddr = ram_a & 32'hFFFF_FFFC;
  end

endmodule

// File: tb/tb_coherence_memory_control.sv
// Directed bench for coherence_memory_control with a latency-programmable RAM model.
module tb_coherence_memory_control;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN [2];
  logic [31:0] iaddr [2];
  logic        iwait [2];
  logic [31:0] iload [2];
  logic        dREN [2];
  logic        dWEN [2];
  logic [31:0] daddr [2];
  logic [31:0] dstore [2];
  logic        dwait [2];
  logic [31:0] dload [2];
  logic        cctrans [2];
  logic        ccwrite [2];
  logic        ccwait [2];
  logic        ccinv [2];
  logic [31:0] ccsnoopaddr [2];
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  int unsigned lat = 2;
  int unsigned bcnt;
  logic        force_err = 1'b0;
  int          n_assert = 0;
  int          n_fail = 0;

  always #5 CLK = ~CLK;

  coherence_memory_control #(.CPUS(2), .BLKWORDS(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  // RAM model: lat BUSY cycles then one ACCESS beat per strobed word.
  assign ramload = (ramaddr == 32'h100) ? 32'hDEAD_BEEF : (ramaddr ^ 32'hA5A5_0000);

  always_comb begin
    if (force_err) ramstate = 2'd3;
    else if (ramREN || ramWEN) ramstate = (bcnt == lat) ? 2'd2 : 2'd1;
    else ramstate = 2'd0;
  end

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) bcnt <= 0;
    else if ((ramREN || ramWEN) && bcnt != lat) bcnt <= bcnt + 1;
    else bcnt <= 0;
  end

  wire [9:0]  ctl = {iwait[0], iwait[1], dwait[0], dwait[1], ccwait[0], ccwait[1],
                     ccinv[0], ccinv[1], ramREN, ramWEN};
  wire [31:0] dor = ramaddr | ramstore | iload[0] | iload[1] | dload[0] | dload[1] |
                    ccsnoopaddr[0] | ccsnoopaddr[1];

  task automatic idle_inputs();
    for (int c = 0; c < 2; c++) begin
      iREN[c] = 0; iaddr[c] = 0; dREN[c] = 0; dWEN[c] = 0; daddr[c] = 0; dstore[c] = 0;
      cctrans[c] = 0; ccwrite[c] = 0;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 1'b0;
    @(negedge CLK);
    n_assert++;
    if (ctl !== 10'b1111000000) begin
      n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, 10'b1111000000);
    end
    n_assert++;
    if (dor !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", dor); end
    nRST = 1'b1;
  endtask

  task automatic test_ifetch();
    int rcnt = 0, lowcnt = 0, other_low = 0;
    logic [31:0] got = 0;
    iREN[0] = 1; iaddr[0] = 32'h100;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (ramREN) rcnt++;
      if (!iwait[1]) other_low++;
      if (!iwait[0]) begin lowcnt++; got = iload[0]; iREN[0] = 0; end
    end
    n_assert++;
    if (lowcnt != 1) begin n_fail++; $display("FAIL ifetch_wait_low: got %0d want 1", lowcnt); end
    n_assert++;
    if (got !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL ifetch_data: got %h want deadbeef", got);
    end
    n_assert++;
    if (rcnt != 3) begin n_fail++; $display("FAIL ifetch_ramren_cycles: got %0d want 3", rcnt); end
    n_assert++;
    if (other_low != 0) begin n_fail++; $display("FAIL ifetch_iwait1: got %0d want 0", other_low); end
  endtask

  task automatic test_fill();
    int words = 0, ccw_cnt = 0, inv_seen = 0;
    logic [31:0] snp = 0;
    logic [31:0] wa [2];
    logic [31:0] wd [2];
    wa[0] = 0; wa[1] = 0; wd[0] = 0; wd[1] = 0;
    dREN[0] = 1; cctrans[0] = 1; ccwrite[0] = 0; daddr[0] = 32'h208;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (ccwait[1]) begin ccw_cnt++; snp = ccsnoopaddr[1]; end
      if (ccinv[0] || ccinv[1]) inv_seen++;
      if (!dwait[0] && words < 2) begin
        wa[words] = ramaddr; wd[words] = dload[0]; words++;
        if (words == 2) begin dREN[0] = 0; cctrans[0] = 0; end
      end
    end
    n_assert++;
    if (words != 2) begin n_fail++; $display("FAIL fill_words: got %0d want 2", words); end
    n_assert++;
    if (ccw_cnt != 1) begin n_fail++; $display("FAIL fill_ccwait_cycles: got %0d want 1", ccw_cnt); end
    n_assert++;
    if (snp !== 32'h208) begin n_fail++; $display("FAIL fill_snoopaddr: got %h want 208", snp); end
    n_assert++;
    if (wa[0] !== 32'h208 || wa[1] !== 32'h20C) begin
      n_fail++; $display("FAIL fill_addrs: got %h %h want 208 20c", wa[0], wa[1]);
    end
    n_assert++;
    if (wd[0] !== 32'hA5A5_0208 || wd[1] !== 32'hA5A5_020C) begin
      n_fail++; $display("FAIL fill_data: got %h %h want a5a50208 a5a5020c", wd[0], wd[1]);
    end
    n_assert++;
    if (inv_seen != 0) begin n_fail++; $display("FAIL fill_ccinv: got %0d want 0", inv_seen); end
  endtask

  task automatic test_supply();
    int words = 0;
    logic [1:0]  inv = 0;
    logic [31:0] ld [2];
    logic [31:0] ra [2];
    logic [31:0] rs [2];
    for (int i = 0; i < 2; i++) begin ld[i] = 0; ra[i] = 0; rs[i] = 0; end
    dWEN[1] = 1; cctrans[1] = 1; ccwrite[1] = 1; daddr[1] = 32'h40;
    for (int k = 0; k < 25; k++) begin
      @(negedge CLK);
      if (ccwait[0]) begin
        cctrans[0] = 1; ccwrite[0] = 1;
        if (words == 0) dstore[0] = 32'h11;
      end
      if (!dwait[1] && words < 2) begin
        ld[words] = dload[1]; ra[words] = ramWEN ? ramaddr : 32'hFFFF_FFFF;
        rs[words] = ramstore; inv[words] = ccinv[0]; words++;
        dstore[0] = 32'h22;
        if (words == 2) idle_inputs();
      end
    end
    n_assert++;
    if (words != 2) begin n_fail++; $display("FAIL supply_words: got %0d want 2", words); end
    n_assert++;
    if (ld[0] !== 32'h11 || ld[1] !== 32'h22) begin
      n_fail++; $display("FAIL supply_dload: got %h %h want 11 22", ld[0], ld[1]);
    end
    n_assert++;
    if (ra[0] !== 32'h40 || ra[1] !== 32'h44) begin
      n_fail++; $display("FAIL supply_ramaddr: got %h %h want 40 44", ra[0], ra[1]);
    end
    n_assert++;
    if (rs[0] !== 32'h11 || rs[1] !== 32'h22) begin
      n_fail++; $display("FAIL supply_ramstore: got %h %h want 11 22", rs[0], rs[1]);
    end
    n_assert++;
    if (inv !== 2'b10) begin n_fail++; $display("FAIL supply_ccinv: got %b want 10", inv); end
  endtask

  task automatic test_rr();
    int nb = 0;
    int w [2];
    int blocks [2];
    int ord [3];
    logic [31:0] fa [3];
    for (int i = 0; i < 3; i++) begin ord[i] = -1; fa[i] = 0; end
    w[0] = 0; w[1] = 0; blocks[0] = 0; blocks[1] = 0;
    nRST = 0; #1; nRST = 1;
    dREN[0] = 1; cctrans[0] = 1; daddr[0] = 32'h300;
    dREN[1] = 1; cctrans[1] = 1; daddr[1] = 32'h400;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      for (int c = 0; c < 2; c++) begin
        if (!dwait[c]) begin
          if (w[c] == 0 && nb < 3) begin ord[nb] = c; fa[nb] = ramaddr; nb++; end
          w[c]++;
          if (w[c] == 2) begin
            w[c] = 0; blocks[c]++;
            if (c == 0 && blocks[0] == 1) daddr[0] = 32'h500;
            else begin dREN[c] = 0; cctrans[c] = 0; end
          end
        end
      end
      if (blocks[0] == 2 && blocks[1] == 1) break;
    end
    n_assert++;
    if (blocks[0] != 2 || blocks[1] != 1) begin
      n_fail++; $display("FAIL rr_done: got %0d %0d want 2 1", blocks[0], blocks[1]);
    end
    n_assert++;
    if (ord[0] != 0 || ord[1] != 1 || ord[2] != 0) begin
      n_fail++; $display("FAIL rr_order: got %0d %0d %0d want 0 1 0", ord[0], ord[1], ord[2]);
    end
    n_assert++;
    if (fa[0] !== 32'h300 || fa[1] !== 32'h400 || fa[2] !== 32'h500) begin
      n_fail++; $display("FAIL rr_addrs: got %h %h %h want 300 400 500", fa[0], fa[1], fa[2]);
    end
  endtask

  task automatic test_wb_priority();
    logic        seen = 0, first_wen = 0, wb_done = 0, after_wb = 0, got_if = 0;
    logic [31:0] first_a = 0, first_d = 0, il = 0;
    iREN[0] = 1; iaddr[0] = 32'h600;
    dWEN[1] = 1; daddr[1] = 32'h80; dstore[1] = 32'h5A;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK);
      if (!seen && (ramREN || ramWEN)) begin
        seen = 1; first_wen = ramWEN; first_a = ramaddr; first_d = ramstore;
      end
      if (!dwait[1]) begin dWEN[1] = 0; wb_done = 1; end
      if (!iwait[0]) begin il = iload[0]; after_wb = wb_done; got_if = 1; iREN[0] = 0; break; end
    end
    n_assert++;
    if (first_wen !== 1'b1) begin n_fail++; $display("FAIL wb_first_is_write: got %b want 1", first_wen); end
    n_assert++;
    if (first_a !== 32'h80 || first_d !== 32'h5A) begin
      n_fail++; $display("FAIL wb_addr_data: got %h %h want 80 5a", first_a, first_d);
    end
    n_assert++;
    if (got_if !== 1'b1 || after_wb !== 1'b1) begin
      n_fail++; $display("FAIL wb_then_ifetch: got %b%b want 11", got_if, after_wb);
    end
    n_assert++;
    if (il !== 32'hA5A5_0600) begin n_fail++; $display("FAIL wb_ifetch_data: got %h want a5a50600", il); end
  endtask

  task automatic test_reset_mid();
    logic        in_fill2 = 0, got = 0;
    logic [31:0] il = 0;
    dREN[0] = 1; cctrans[0] = 1; daddr[0] = 32'h700;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (!dwait[0]) break;
    end
    @(negedge CLK);
    in_fill2 = ramREN && (ramaddr == 32'h704);
    n_assert++;
    if (!in_fill2) begin n_fail++; $display("FAIL mid_fill2: got %b %h want 1 704", ramREN, ramaddr); end
    #1 nRST = 0;
    idle_inputs();
    #1;
    n_assert++;
    if (ctl !== 10'b1111000000) begin
      n_fail++; $display("FAIL mid_reset_ctl: got %b want %b", ctl, 10'b1111000000);
    end
    n_assert++;
    if (dor !== 32'h0) begin n_fail++; $display("FAIL mid_reset_data: got %h want 0", dor); end
    #1 nRST = 1;
    iREN[1] = 1; iaddr[1] = 32'h104;
    for (int k = 0; k < 15; k++) begin
      @(negedge CLK);
      if (!iwait[1]) begin got = 1; il = iload[1]; iREN[1] = 0; break; end
    end
    n_assert++;
    if (!got || il !== 32'hA5A5_0104) begin
      n_fail++; $display("FAIL mid_after_release: got %b %h want 1 a5a50104", got, il);
    end
  endtask

  task automatic test_error();
    int bad = 0;
    logic hit = 0;
    iREN[0] = 1; iaddr[0] = 32'h900;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (ramREN) begin hit = 1; force_err = 1; #1; if (!iwait[0]) bad++; break; end
    end
    @(negedge CLK);
    force_err = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (!iwait[0] || ramREN || ramWEN) bad++;
    end
    n_assert++;
    if (!hit) begin n_fail++; $display("FAIL err_no_fetch: got 0 want 1"); end
    n_assert++;
    if (bad != 0) begin n_fail++; $display("FAIL err_hold: got %0d bad cycles want 0", bad); end
    idle_inputs();
    nRST = 0; #1; nRST = 1;
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_fill();
    test_supply();
    test_rr();
    test_wb_priority();
    test_reset_mid();
    test_error();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
